// File: rtl/serial_add_pkg.sv
// Shared types and defaults for the bit-serial adder controller.
package serial_add_pkg;

  localparam int SA_WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/half_adder.sv
// One-bit half adder cell; purely combinational.
module half_adder (
  input  logic a_i,
  input  logic b_i,
  output logic s_o,
  output logic c_o
);

  assign s_o = a_i ^ b_i;
  assign c_o = a_i & b_i;

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full-adder slice stepped over WIDTH cycles, done WIDTH cycles after accept.
// start is only honoured in IDLE; there is no queueing, so a requester must hold or re-assert it.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = SA_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;

  logic ha0_s, ha0_c, ha1_c, bit_s, bit_co;

  // Full-adder slice: two half adders, carries ORed.
  half_adder u_ha0 (
    .a_i (a_sh_q[0]),
    .b_i (b_sh_q[0]),
    .s_o (ha0_s),
    .c_o (ha0_c)
  );

  half_adder u_ha1 (
    .a_i (ha0_s),
    .b_i (carry_q),
    .s_o (bit_s),
    .c_o (ha1_c)
  );

  assign bit_co = ha0_c | ha1_c;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          a_sh_d  = a;
          b_sh_d  = b;
          sum_d   = '0;
          cnt_d   = '0;
          carry_d = 1'b0;
        end
      end
      RUN: begin
        // LSB first: each result bit enters at the top and walks down to its place.
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        sum_d   = {bit_s, sum_q[WIDTH-1:1]};
        carry_d = bit_co;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
          cout_d  = bit_co;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs decode straight from flops; no input reaches an output combinationally.
  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: doc/serial_add_ctrl.md
# serial_add_ctrl

Bit-serial adder controller that sequences a single one-bit adder cell over WIDTH cycles to add two WIDTH-bit operands. Two instances of the team's half_adder cell plus an OR form the full-adder slice. The controller owns operand shifting, the carry flop, the bit counter and the start/done handshake. It sits between a requester that presents operands and a consumer that reads the registered sum, trading area for latency.

## Interface
- WIDTH, default 8: operand/sum width in bits; legal range 2..32.
- clk  in  1  rising-edge clock; the only clock.
- rst_n  in  1  reset, synchronous and active-low.
- start  in  1  request; sampled only in IDLE.
- a  in  WIDTH  operand A; sampled on the accepting edge only.
- b  in  WIDTH  operand B; sampled on the accepting edge only.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse; sum/cout valid.
- sum  out  WIDTH  registered result, a+b mod 2^WIDTH.
- cout  out  1  carry out of bit WIDTH-1.

## Operation
- States: IDLE, RUN, DONE.
  - IDLE -> RUN on start=1.
  - RUN -> DONE when bit counter = WIDTH-1.
  - DONE -> IDLE unconditionally.
- Accept (IDLE, start=1):
  - a_sh<=a, b_sh<=b, carry<=0, cnt<=0, sum<=0.
- Each RUN cycle uses slice inputs a_sh[0], b_sh[0], carry. It computes s = a^b^c and co = (a&b)|((a^b)&c).
  - a_sh, b_sh shift right by one.
  - sum shifts right with s inserted at bit WIDTH-1.
  - carry<=co; cnt<=cnt+1.
- On the RUN->DONE edge, cout<=co of the final bit.
- sum and cout hold from DONE until the next accepted start. They are not cleared on returning to IDLE.
- Boundary conditions:
  - start while in RUN or DONE is ignored. There is no queueing; the requester must hold start or re-assert it in IDLE.
  - Operand changes after the accepting edge have no effect.
  - cnt width is clog2(WIDTH). There is no wrap-around inside an operation; cnt resets on every accept.
- Reset (rst_n=0 at any edge, including mid-RUN):
  - state<=IDLE; busy, done, cout <= 0; sum <= 0; carry <= 0; cnt <= 0.
  - An aborted operation produces no done.

## Timing
- All outputs are registered; no combinational input-to-output path.
- Edge numbering: start is accepted at edge E0.
  - busy=1 from E0 through E0+WIDTH, i.e. for exactly WIDTH cycles.
  - done=1 for the single cycle between E0+WIDTH and E0+WIDTH+1.
  - Latency from the accepting edge to done is WIDTH cycles.
- Throughput: the earliest next accept is E0+WIDTH+2, i.e. start high in the IDLE cycle after DONE. One operation completes per WIDTH+2 cycles.
- done and busy are never high in the same cycle.

## Structure
- Package serial_add_pkg:
  - state enum {IDLE, RUN, DONE}.
  - default WIDTH constant.
- Sub-module: the existing half_adder cell, instantiated twice for the full-adder slice.
- No other sub-modules. The FSM, shift registers and counter stay in serial_add_ctrl.

## Test plan
- WIDTH=8, a=8'h03, b=8'h05, start for one cycle:
  - busy high for 8 cycles, done 8 cycles after accept;
  - sum=8'h08, cout=0.
- a=8'hFF, b=8'h01 -> sum=8'h00, cout=1. Then a=8'hFF, b=8'hFF -> sum=8'hFE, cout=1.
- start held high continuously:
  - accepts occur every 10 cycles;
  - start pulses during RUN/DONE are ignored;
  - operands changed mid-RUN do not alter the result.
- rst_n=0 for one cycle at the 4th RUN cycle of 8'hAA+8'h55:
  - next cycle busy=0, done=0, sum=0, cout=0, no done pulse follows;
  - a fresh 8'h01+8'h01 then yields sum=8'h02, cout=0 (carry cleared).
- After done, hold start=0 for 20 cycles -> sum/cout stay stable and done stays 0.
- WIDTH=2, exhaustive a,b in 0..3 -> sum=(a+b)&3, cout=(a+b)>>2, done 2 cycles after each accept.
